dcache_ctrl: RTL
================

# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller between the MEM stage and the off-chip data memory. It answers CPU load/store requests and generates the memory stall (`stall_o`). The hazard logic fans `stall_o` out to the PC's `MemStall_i` and to every pipeline register. On a miss it runs an optional dirty-line writeback, then a line refill, over a request/acknowledge memory bus. It releases the stall once the line is resident.

## Interface
- `SETS`, 16: number of cache lines; power of two, at least 2.
- `IDX_W`, log2(SETS) = 4: index width.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; asynchronous, active-high.
- `cpu_req_i` in 1: MEM stage access valid (MemRead | MemWrite).
- `cpu_wr_i` in 1: 1 = store, 0 = load; qualified by `cpu_req_i`.
- `cpu_addr_i` in 32: byte address; bits [1:0] ignored.
- `cpu_data_i` in 32: store data.
- `cpu_data_o` out 32: load data; valid when `cpu_req_i & ~cpu_wr_i & ~stall_o`.
- `stall_o` out 1: memory stall to the PC and pipeline registers.
- `mem_enable_o` out 1: memory request, held until acknowledged.
- `mem_write_o` out 1: 1 = line write, 0 = line read.
- `mem_addr_o` out 32: line-aligned address; bits [4:0] = 0.
- `mem_data_o` out 256: writeback line.
- `mem_data_i` in 256: refill line.
- `mem_ack_i` in 1: one-cycle pulse completing the current memory request.

## Operation
- **Address split:**
  - offset = `cpu_addr_i`[4:0] (32-byte line); word select = [4:2].
  - index = [4+IDX_W:5].
  - tag = [31:5+IDX_W].
- **Storage:** per line, 1 valid bit, 1 dirty bit, a tag, and 256 data bits, all in flops. Word w occupies bits [32w+31:32w].
- **Hit:** valid[index] & (tag[index] == tag).
- **`stall_o`:** combinational; `stall_o = cpu_req_i & ~hit`, OR'd with state != IDLE and state != REFILL_DONE.
- **Loads:** `cpu_data_o` = selected word of the indexed line, driven combinationally. It is 0 when `cpu_req_i` is low.
- **Store hit:** at the clock edge, write the selected word and set dirty.
- **States:** IDLE, WRITEBACK, REFILL, REFILL_DONE.
- **Transitions:**
  - IDLE, `cpu_req_i & ~hit`, victim valid & dirty → WRITEBACK.
    - `mem_addr_o` = {victim tag, index, 5'b0}; `mem_write_o` = 1; `mem_data_o` = victim line.
  - IDLE, `cpu_req_i & ~hit`, victim clean or invalid → REFILL.
    - `mem_addr_o` = {tag, index, 5'b0}; `mem_write_o` = 0.
  - WRITEBACK, `mem_ack_i` → REFILL.
    - `mem_enable_o` stays high; the address switches to the requested line and `mem_write_o` drops.
  - REFILL, `mem_ack_i` → REFILL_DONE.
    - At this edge the line is loaded from `mem_data_i`, valid = 1, dirty = 0, tag updated.
  - REFILL_DONE → IDLE, unconditionally.
    - The access now hits, so `stall_o` is low in this cycle. A pending store is merged at this edge and sets dirty.
- **Memory outputs:** `mem_enable_o` = 1 exactly in WRITEBACK and REFILL. `mem_addr_o`, `mem_write_o` and `mem_data_o` are registered and stable while `mem_enable_o` is high.
- **Ignored acknowledges:** `mem_ack_i` in IDLE or REFILL_DONE is ignored.
- **CPU hold requirement:** the CPU holds `cpu_req_i`, `cpu_wr_i`, `cpu_addr_i` and `cpu_data_i` stable while `stall_o` = 1. The stall itself guarantees this. Behaviour when they change mid-miss is undefined.

## Timing
- **Reset values:**
  - state IDLE; all valid and dirty bits 0; tag and data arrays not reset.
  - `mem_enable_o` 0, `mem_write_o` 0, `mem_addr_o` 0, `mem_data_o` 0.
  - `cpu_data_o` 0 while `cpu_req_i` is low.
  - `stall_o` = `cpu_req_i`, because every line is invalid after reset.
- **Hit latency:** 0 cycles of stall; load data is available in the same cycle.
- **Clean miss, memory ack N cycles after the request:**
  - cycle 0: IDLE, miss detected.
  - cycles 1..N: REFILL.
  - cycle N+1: REFILL_DONE, `stall_o` = 0.
- **Dirty miss:** adds the writeback ack latency before REFILL.
- **Reset mid-miss:** outputs drop asynchronously, the FSM returns to IDLE, and all lines are invalidated. Any in-flight memory transaction is abandoned.
- **Ack in the same cycle the request is issued:** impossible by construction; the request is registered at the IDLE→WRITEBACK/REFILL edge.
- **Consecutive requests:** a miss to a different set directly after REFILL_DONE starts in the following IDLE cycle.

## Test plan
- **Cold load:** after reset, load `0x0000_0040` with the memory returning a line whose word 0 = `0x1234_5678` after 10 cycles.
  - Expect `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o`=`0x40`, stall for 11 cycles, then `cpu_data_o`=`0x1234_5678`.
- **Load hit:** repeat the load of `0x40`.
  - Expect `stall_o`=0 in the same cycle, no memory request, data `0x1234_5678`.
- **Store hit then dirty eviction:**
  - Store `0xDEAD_BEEF` to `0x44`; expect no stall.
  - Then load `0x0000_0240`, same index 2 with SETS=16, different tag.
  - Expect a WRITEBACK to `0x40` with `mem_data_o`[63:32]=`0xDEAD_BEEF`, then a REFILL of `0x240`.
- **Write-allocate miss:**
  - Store `0xCAFE_0001` to an uncached `0x1000`; expect a refill, then the merged word, dirty=1.
  - A subsequent load of `0x1000` returns `0xCAFE_0001` with no stall.
- **Reset mid-refill:** assert `rst_i` during REFILL.
  - Expect `mem_enable_o`=0 immediately.
  - A load of `0x40` afterwards misses again.
- **Spurious ack:** pulse `mem_ack_i` while IDLE with no request.
  - Expect no state change and no outputs asserted.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// Lines live in flops; a miss runs an optional dirty writeback, then a refill over a req/ack bus.
module dcache_ctrl #(
  parameter int unsigned SETS  = 16,
  parameter int unsigned IDX_W = $clog2(SETS)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_wr_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);
  localparam int unsigned LINE_W = 256;
  localparam int unsigned TAG_W  = 32 - 5 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, REFILL_DONE} state_e;

  state_e              state_q;
  logic [SETS-1:0]     valid_q;
  logic [SETS-1:0]     dirty_q;
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic [LINE_W-1:0]   data_q [SETS];
  logic                mem_enable_q;
  logic                mem_write_q;
  logic [31:0]         mem_addr_q;
  logic [LINE_W-1:0]   mem_data_q;

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic [7:0]          woff;
  logic                hit;
  logic                busy;
  logic                store_we;
  logic                refill_we;
  logic                victim_dirty;
  logic                addr_unused;

  assign idx          = cpu_addr_i[5 +: IDX_W];
  assign tag          = cpu_addr_i[31 -: TAG_W];
  assign woff         = {cpu_addr_i[4:2], 5'b0};
  assign addr_unused  = ^cpu_addr_i[1:0];
  assign hit          = valid_q[idx] && (tag_q[idx] == tag);
  assign busy         = (state_q == WRITEBACK) || (state_q == REFILL);
  assign stall_o      = (cpu_req_i && !hit) || busy;
  assign cpu_data_o   = cpu_req_i ? data_q[idx][woff +: 32] : 32'h0;
  // A store commits whenever the access is not stalled, including the REFILL_DONE merge.
  assign store_we     = cpu_req_i && cpu_wr_i && !stall_o;
  assign refill_we    = (state_q == REFILL) && mem_ack_i;
  assign victim_dirty = valid_q[idx] && dirty_q[idx];

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  // Tag and data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge clk_i) begin
    if (refill_we) begin
      data_q[idx] <= mem_data_i;
      tag_q[idx]  <= tag;
    end else if (store_we) begin
      data_q[idx][woff +: 32] <= cpu_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_data_q   <= '0;
    end else begin
      if (refill_we) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
      if (store_we) begin
        dirty_q[idx] <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (cpu_req_i && !hit) begin
            mem_enable_q <= 1'b1;
            if (victim_dirty) begin
              state_q     <= WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_q[idx], idx, 5'b0};
              mem_data_q  <= data_q[idx];
            end else begin
              state_q     <= REFILL;
              mem_write_q <= 1'b0;
              mem_addr_q  <= {tag, idx, 5'b0};
            end
          end
        end
        WRITEBACK: begin
          // Request stays up; it turns into the refill read of the wanted line.
          if (mem_ack_i) begin
            state_q     <= REFILL;
            mem_write_q <= 1'b0;
            mem_addr_q  <= {tag, idx, 5'b0};
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            state_q      <= REFILL_DONE;
            mem_enable_q <= 1'b0;
          end
        end
        REFILL_DONE: state_q <= IDLE;
        default:     state_q <= IDLE;
      endcase
    end
  end
endmodule
